// File: rtl/bit_word_packer_pkg.sv
// Shared helpers for bit_word_packer: beat-count and counter-width functions
// plus a parameter legality check evaluated at elaboration time.
package packer_pkg;

  // Number of beats that make up a full word.
  function automatic int beats(input int data_bits, input int chunk);
    return data_bits / chunk;
  endfunction

  // Width needed to hold any value in 0..n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Width of an index that walks 0..n-1 (never narrower than one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // True when the parameter set describes a buildable packer.
  function automatic bit params_ok(input int out_width, input int data_bits, input int chunk);
    return (chunk >= 1) && (data_bits >= 1) && (data_bits <= out_width) &&
           ((data_bits % chunk) == 0);
  endfunction

endpackage

// File: rtl/bit_word_packer_out_reg.sv
// pack_out_reg: output holding register of bit_word_packer with valid/ready
// load/drain control and the fill stage for bits above the packed field.
// Build option: BIT_WORD_PACKER_SIGN_EXTEND_EN selects sign fill instead of zero fill.
module pack_out_reg
  import packer_pkg::*;
#(
  parameter int OUT_WIDTH = 8,
  parameter int DATA_BITS = 7,
  parameter int CW        = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] word,
  input  logic [CW-1:0]        count,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [CW-1:0]        out_count
);

  logic                 fill_bit;
  logic [OUT_WIDTH-1:0] filled;

`ifdef BIT_WORD_PACKER_SIGN_EXTEND_EN
  // Fill value is the top significant bit of the packed field (bit count-1).
  always_comb begin
    fill_bit = 1'b0;
    for (int i = 0; i < DATA_BITS; i++) begin
      if (count == CW'(i + 1)) fill_bit = word[i];
    end
  end
`else
  assign fill_bit = 1'b0;
`endif

  // Bits below count come from the packed field; everything above takes the fill value.
  for (genvar gi = 0; gi < OUT_WIDTH; gi++) begin : g_fill
    if (gi < DATA_BITS) begin : g_field
      assign filled[gi] = (CW'(gi) < count) ? word[gi] : fill_bit;
    end else begin : g_pad
      assign filled[gi] = fill_bit;
    end
  end

  // Load on a completed word (even while draining), otherwise drop valid after a transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= filled;
      out_count <= count;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/bit_word_packer.sv
// bit_word_packer: assembles LSB-first CHUNK-bit beats into DATA_BITS significant
// bits of an OUT_WIDTH-bit word, with early close via in_last and valid/ready
// on both sides. Build option: BIT_WORD_PACKER_SIGN_EXTEND_EN (sign fill, see pack_out_reg).
module bit_word_packer
  import packer_pkg::*;
#(
  parameter int OUT_WIDTH = 8,
  parameter int DATA_BITS = 7,
  parameter int CHUNK     = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [CHUNK-1:0]                in_data,
  input  logic                            in_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [OUT_WIDTH-1:0]            out_data,
  output logic [cnt_w(DATA_BITS)-1:0]     out_count
);

  localparam int BEATS = beats(DATA_BITS, CHUNK);
  localparam int CW    = cnt_w(DATA_BITS);
  localparam int BW    = idx_w(BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  if (!params_ok(OUT_WIDTH, DATA_BITS, CHUNK)) begin : g_param_check
    $error("bit_word_packer: need 1 <= DATA_BITS <= OUT_WIDTH and DATA_BITS %% CHUNK == 0");
  end

  logic [DATA_BITS-1:0] acc_reg;
  logic [BW-1:0]        beat_cnt_reg;
  logic                 accept;
  logic                 complete;
  logic [DATA_BITS-1:0] merged;
  logic [CW-1:0]        word_count;

  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign complete   = accept && (in_last || (beat_cnt_reg == LAST_BEAT));
  assign word_count = CW'((32'(beat_cnt_reg) + 32'd1) * CHUNK);

  // Slots below the current beat keep accumulated data, the current slot takes
  // the incoming beat, and slots above are forced to zero.
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_slot
    assign merged[gi*CHUNK +: CHUNK] =
        (BW'(gi) < beat_cnt_reg)  ? acc_reg[gi*CHUNK +: CHUNK] :
        (BW'(gi) == beat_cnt_reg) ? in_data : '0;
  end

  // Accumulate beats; restart from an empty word once a word is handed off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_reg      <= '0;
      beat_cnt_reg <= '0;
    end else if (accept) begin
      if (complete) begin
        acc_reg      <= '0;
        beat_cnt_reg <= '0;
      end else begin
        acc_reg      <= merged;
        beat_cnt_reg <= beat_cnt_reg + BW'(1);
      end
    end
  end

  pack_out_reg #(
    .OUT_WIDTH (OUT_WIDTH),
    .DATA_BITS (DATA_BITS),
    .CW        (CW)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (complete),
    .word      (merged),
    .count     (word_count),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_count (out_count)
  );

endmodule

// File: doc/bit_word_packer.md
Name: bit_word_packer

Overview:
- Parametrised, sequential successor to the fixed 7-in/8-out bit maker used in the Intcode datapath.
- Accepts a stream of CHUNK-bit beats LSB-first and assembles them into DATA_BITS significant bits of an OUT_WIDTH-bit word.
- Unused upper bits are zero-filled; a word may be closed early with in_last.
- Valid/ready on both sides. Sits between serial decode logic (opcode/mode digit extraction) and the word-wide Intcode register file.

Parameters:
- OUT_WIDTH, 8, width of the emitted word.
- DATA_BITS, 7, significant bits per full word. Must satisfy 1 <= DATA_BITS <= OUT_WIDTH.
- CHUNK, 1, bits per input beat. DATA_BITS % CHUNK must be 0. BEATS = DATA_BITS/CHUNK.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low; all state cleared while low.
- in_valid  in  1  input beat present.
- in_ready  out  1  packer can take a beat.
- in_data  in  CHUNK  beat payload.
- in_last  in  1  close the current word after this beat (flush).
- out_valid  out  1  word held in output register.
- out_ready  in  1  consumer accepts the word.
- out_data  out  OUT_WIDTH  assembled word.
- out_count  out  clog2(DATA_BITS+1)  number of significant bits in out_data.

Behaviour:
- Reset (rst low, async):
  - acc=0, beat_cnt=0, out_valid=0, out_data=0, out_count=0.
  - in_ready goes high as soon as rst is released, because out_valid=0.
- Handshake:
  - in_ready = !out_valid || out_ready. This is combinational from out_ready and does not depend on in_valid, in_data or in_last.
  - A beat is accepted when in_valid && in_ready.
  - A word transfers when out_valid && out_ready.
- Placement: the beat at index k (k = beat_cnt) occupies bits [k*CHUNK +: CHUNK] of the word.
- Completion beat: an accepted beat with beat_cnt==BEATS-1 or in_last=1.
  - On the next edge, the output register loads acc merged with this beat. Bits at or above (beat_cnt+1)*CHUNK are forced to 0.
  - out_count loads (beat_cnt+1)*CHUNK and out_valid is set.
  - acc and beat_cnt clear to 0.
- Non-completion beat: acc stores the beat at its slot and beat_cnt increments.
- Latency: the word is visible on out_data the cycle after the completion beat.
- Throughput: one beat per cycle with out_ready held high.
- Output register behaviour:
  - A transfer with no new completion clears out_valid.
  - A transfer in the same cycle as a new completion reloads the register; out_valid stays 1 with no bubble.
  - out_data and out_count are stable while out_valid && !out_ready.
- Back-pressure:
  - While out_valid && !out_ready, in_ready=0; acc and beat_cnt hold.
  - Partial accumulation never stalls on its own.
- in_last on the first beat (beat_cnt=0) emits a word containing CHUNK significant bits.
- in_last on a beat with beat_cnt==BEATS-1 is an ordinary full word.
- in_last without in_valid is ignored.
- A partial word is never emitted without in_last; there is no timeout.
- Reset mid-word or while out_valid=1 discards everything. No word is emitted after reset.
- Bits of out_data in [DATA_BITS, OUT_WIDTH) are always 0, unless the optional feature below is enabled.

Optional Feature:
- Macro: BIT_WORD_PACKER_SIGN_EXTEND_EN.
- Defined: all bits of out_data at or above out_count are filled with bit out_count-1 (two's-complement sign extension of the packed field).
- Undefined: those bits are zero-filled.
- Handshake and latency are identical in both builds.

Decomposition:
- Shared package packer_pkg holds:
  - function beats(DATA_BITS, CHUNK);
  - function cnt_w(n) returning clog2(n+1);
  - localparam-checking function used in an elaboration-time assertion (DATA_BITS % CHUNK==0, DATA_BITS<=OUT_WIDTH).
- One natural sub-module: pack_out_reg. It is the output holding register with the valid/ready load/drain logic and the fill (zero or sign) stage.
- The accumulator and beat counter stay in the top module.

Test Plan:
- Defaults (8/7/1): bits 1,0,1,0,1,0,1 on consecutive cycles, out_ready=1 -> one cycle after the 7th beat, out_data=0x55, out_count=7, out_valid for exactly 1 cycle.
- Defaults: bits 1,1,0 with in_last on 3rd beat -> out_data=0x03, out_count=3. With SIGN_EXTEND_EN: bits 1,0,1 + in_last -> out_data=0xFD.
- OUT_WIDTH=16, DATA_BITS=12, CHUNK=4: beats 0xA,0xB,0xC -> out_data=0x0CBA, out_count=12. Continuous input produces back-to-back words with no bubble.
- out_ready=0 while a word is pending -> in_ready=0; out_data/out_count stable for 5 cycles. Release -> next word completes in order with no beat lost or duplicated.
- rst pulsed low asynchronously mid-word after 4 beats -> out_valid=0 immediately. Next 7 beats form a fresh word with no residue from the first 4.
- in_last asserted with in_valid=0 -> no effect. in_last on the first beat, bit=1 -> out_data=0x01, out_count=1.
